// File: rtl/exe_pipe_if.sv
// Handshake bundle for the execute stage: decoded instruction from DEC on the
// input side, registered result toward WB on the output side.
interface exe_pipe_if #(
  parameter int XLEN = 32,
  parameter int REGW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_in;
  logic [1:0]      instr_type;
  logic            is_computational;
  logic            is_load;
  logic            is_store;
  logic [REGW-1:0] rs2;
  logic [REGW-1:0] rd;
  logic            needs_wb;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] exe_out;
  logic            z_flag;
  logic [XLEN-1:0] pc_out;
  logic [REGW-1:0] rd_out;
  logic            needs_wb_out;
  logic            is_load_out;
  logic            is_store_out;
  logic            busy;

  modport master (
    output in_valid, rs1_val, rs2_val, imm, pc_in, instr_type, is_computational,
           is_load, is_store, rs2, rd, needs_wb, out_ready,
    input  in_ready, out_valid, exe_out, z_flag, pc_out, rd_out, needs_wb_out,
           is_load_out, is_store_out, busy
  );

  modport slave (
    input  in_valid, rs1_val, rs2_val, imm, pc_in, instr_type, is_computational,
           is_load, is_store, rs2, rd, needs_wb, out_ready,
    output in_ready, out_valid, exe_out, z_flag, pc_out, rd_out, needs_wb_out,
           is_load_out, is_store_out, busy
  );
endinterface

// File: rtl/exe_pipe_stage.sv
// Execute stage: single-cycle ALU / branch compare / pc+imm target, an iterative
// shift-add multiplier, and a 1-entry output register toward WB.
module exe_pipe_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 4
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  exe_pipe_if.slave bus
);
  localparam int         SHW    = $clog2(XLEN);
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [SHW-1:0]  cnt;

  logic [3:0]      op;
  logic [XLEN-1:0] op1, op2;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] target;
  logic            cond;

  logic            drain_ok;
  logic            in_ready;
  logic            accept;
  logic            is_mul;
  logic            load_alu;
  logic            load_mul;
  logic            start_mul;

  logic [XLEN-1:0] mcand, mplier, acc;
  logic [XLEN-1:0] m_pc;
  logic [REGW-1:0] m_rd;
  logic            m_needs_wb, m_is_load, m_is_store;

  logic            out_valid_q;
  logic [XLEN-1:0] exe_out_q;
  logic            z_flag_q;
  logic [XLEN-1:0] pc_out_q;
  logic [REGW-1:0] rd_out_q;
  logic            needs_wb_q, is_load_q, is_store_q;

  // Operation field lives in a different instruction slot per format.
  always_comb begin
    // NOTE: every variable driven from an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    op = 4'd0;
    case (bus.instr_type)
      2'b00:   op = bus.imm[3:0];
      2'b01:   op = bus.rd[3:0];
      2'b10:   op = bus.rs2[3:0];
      default: op = 4'd0;
    endcase
  end

  always_comb begin
    op1     = bus.rs1_val;
    op2     = (bus.instr_type[1] || bus.is_load || bus.is_store) ? bus.imm : bus.rs2_val;
    shamt   = op2[SHW-1:0];
    target  = bus.pc_in + bus.imm;
    alu_res = '0;
    case (op)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = op1 & op2;
      4'd3:    alu_res = op1 | op2;
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = op1 << shamt;
      4'd6:    alu_res = op1 >> shamt;
      4'd7:    alu_res = $signed(op1) >>> shamt;
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      default: alu_res = '0;  // MUL is produced by the iterative unit
    endcase
    cond = 1'b0;
    case (op)
      4'd0:    cond = (op1 == op2);
      4'd1:    cond = (op1 != op2);
      4'd2:    cond = ($signed(op1) <  $signed(op2));
      4'd3:    cond = ($signed(op1) >= $signed(op2));
      4'd4:    cond = (op1 <  op2);
      4'd5:    cond = (op1 >= op2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    drain_ok  = !out_valid_q || bus.out_ready;
    in_ready  = (state == IDLE) && drain_ok && !flush;
    accept    = bus.in_valid && in_ready;
    is_mul    = bus.is_computational && (op == OP_MUL);
    state_d   = state;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d   = MUL;
            start_mul = 1'b1;
          end else begin
            load_alu  = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == SHW'(XLEN - 1)) state_d = DONE;
      end
      DONE: begin
        if (drain_ok) begin
          state_d  = IDLE;
          load_mul = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush kills the multiplier and any pending load; reset still dominates it.
    if (flush) begin
      state_d   = IDLE;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
      start_mul = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state is updated only with non-blocking assignments so
      // every flop samples pre-edge values, matching the synthesized hardware.
      state <= state_d;
      cnt   <= (state == MUL && state_d == MUL) ? cnt + 1'b1 : '0;
    end
  end

  // One multiplier bit per cycle: add the shifted multiplicand when the LSB is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the working registers are reset as well; they are few, and it keeps
      // the stage fully deterministic after an abort instead of relying on reload.
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      m_pc       <= '0;
      m_rd       <= '0;
      m_needs_wb <= 1'b0;
      m_is_load  <= 1'b0;
      m_is_store <= 1'b0;
    end else if (start_mul) begin
      mcand      <= op1;
      mplier     <= op2;
      acc        <= '0;
      m_pc       <= bus.pc_in;
      m_rd       <= bus.rd;
      m_needs_wb <= bus.needs_wb;
      m_is_load  <= bus.is_load;
      m_is_store <= bus.is_store;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Output entry: a new load may replace a draining entry on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      exe_out_q   <= '0;
      z_flag_q    <= 1'b0;
      pc_out_q    <= '0;
      rd_out_q    <= '0;
      needs_wb_q  <= 1'b0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
    end else if (load_alu) begin
      out_valid_q <= 1'b1;
      exe_out_q   <= bus.is_computational ? alu_res : target;
      z_flag_q    <= cond;
      pc_out_q    <= bus.pc_in;
      rd_out_q    <= bus.rd;
      needs_wb_q  <= bus.needs_wb;
      is_load_q   <= bus.is_load;
      is_store_q  <= bus.is_store;
    end else if (load_mul) begin
      out_valid_q <= 1'b1;
      exe_out_q   <= acc;
      z_flag_q    <= 1'b0;
      pc_out_q    <= m_pc;
      rd_out_q    <= m_rd;
      needs_wb_q  <= m_needs_wb;
      is_load_q   <= m_is_load;
      is_store_q  <= m_is_store;
    end else if (flush || (out_valid_q && bus.out_ready)) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.busy         = (state == MUL);
  assign bus.out_valid    = out_valid_q;
  assign bus.exe_out      = exe_out_q;
  assign bus.z_flag       = z_flag_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.rd_out       = rd_out_q;
  assign bus.needs_wb_out = needs_wb_q;
  assign bus.is_load_out  = is_load_q;
  assign bus.is_store_out = is_store_q;
endmodule

// File: tb/tb_exe_pipe_stage.sv
// Directed bench for exe_pipe_stage: a transaction-level result queue checks
// every valid output cycle, plus hand-computed literal expectations.
module tb_exe_pipe_stage;
  localparam int XLEN = 32;
  localparam int REGW = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  exe_pipe_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  exe_pipe_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  typ;
    logic        comp, ld, st, wb;
    logic [31:0] rs1, rs2v, imm, pc;
    logic [3:0]  rs2, rd;
  } instr_t;

  typedef struct packed {
    logic [31:0] val;
    logic        z;
    logic [31:0] pc;
    logic [3:0]  rd;
    logic        wb, ld, st;
  } res_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the stage must produce for an instruction, straight from the ISA rules.
  function automatic res_t model(input instr_t i);
    res_t        r;
    logic [3:0]  op;
    logic [31:0] a, b;
    case (i.typ)
      2'b00:   op = i.imm[3:0];
      2'b01:   op = i.rd;
      2'b10:   op = i.rs2;
      default: op = 4'd0;
    endcase
    a = i.rs1;
    b = (i.typ[1] || i.ld || i.st) ? i.imm : i.rs2v;
    r.val = 32'd0;
    if (i.comp) begin
      case (op)
        4'd0:  r.val = a + b;
        4'd1:  r.val = a - b;
        4'd2:  r.val = a & b;
        4'd3:  r.val = a | b;
        4'd4:  r.val = a ^ b;
        4'd5:  r.val = a << b[4:0];
        4'd6:  r.val = a >> b[4:0];
        4'd7:  r.val = $signed(a) >>> b[4:0];
        4'd8:  r.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd9:  r.val = (a < b) ? 32'd1 : 32'd0;
        4'd10: r.val = a * b;
        default: r.val = 32'd0;
      endcase
    end else begin
      r.val = i.pc + i.imm;
    end
    case (op)
      4'd0:    r.z = (a == b);
      4'd1:    r.z = (a != b);
      4'd2:    r.z = ($signed(a) < $signed(b));
      4'd3:    r.z = ($signed(a) >= $signed(b));
      4'd4:    r.z = (a < b);
      4'd5:    r.z = (a >= b);
      default: r.z = 1'b0;
    endcase
    r.pc = i.pc;
    r.rd = i.rd;
    r.wb = i.wb;
    r.ld = i.ld;
    r.st = i.st;
    return r;
  endfunction

  function automatic instr_t mk(input logic [1:0] typ, input logic comp, input logic ld,
                                input logic st, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] im, input logic [31:0] pc,
                                input logic [3:0] r2, input logic [3:0] r);
    instr_t i;
    i.typ = typ; i.comp = comp; i.ld = ld; i.st = st; i.wb = r[0];
    i.rs1 = a; i.rs2v = b; i.imm = im; i.pc = pc; i.rs2 = r2; i.rd = r;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.instr_type       = i.typ;
    bus.is_computational = i.comp;
    bus.is_load          = i.ld;
    bus.is_store         = i.st;
    bus.needs_wb         = i.wb;
    bus.rs1_val          = i.rs1;
    bus.rs2_val          = i.rs2v;
    bus.imm              = i.imm;
    bus.pc_in            = i.pc;
    bus.rs2              = i.rs2;
    bus.rd               = i.rd;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input instr_t i, output int waited);
    logic ok;
    drive(i);
    bus.in_valid = 1'b1;
    ok     = 1'b0;
    waited = 0;
    while (!ok && waited < 100) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        exp_q.push_back(model(i));
        ok = 1'b1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!ok) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input string nm, input instr_t i, input logic [31:0] ev, input logic ez);
    int w;
    issue(i, w);
    #1;
    check({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({nm, "_val"}, bus.exe_out, ev);
    check({nm, "_z"}, {31'd0, bus.z_flag}, {31'd0, ez});
    @(negedge clk);
  endtask

  // Counts falling edges after the accept edge until out_valid shows up.
  task automatic wait_valid(output int edges, output int busy_cycles, input logic chk_ready);
    edges       = 0;
    busy_cycles = 0;
    while (edges < 60) begin
      #1;
      if (bus.out_valid) break;
      if (bus.busy) busy_cycles++;
      if (chk_ready) check("in_ready_while_mul", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      edges++;
    end
    if (edges >= 60) check("mul_result_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({nm, "_busy"},      {31'd0, bus.busy}, 32'd0);
    check({nm, "_in_ready"},  {31'd0, bus.in_ready}, 32'd1);
    check({nm, "_exe_out"},   bus.exe_out, 32'd0);
    check({nm, "_z"},         {31'd0, bus.z_flag}, 32'd0);
    check({nm, "_pc_out"},    bus.pc_out, 32'd0);
    check({nm, "_rd_out"},    {28'd0, bus.rd_out}, 32'd0);
    check({nm, "_side"},      {29'd0, bus.needs_wb_out, bus.is_load_out, bus.is_store_out}, 32'd0);
  endtask

  // Every cycle the output entry is valid it must equal the oldest expected result.
  initial begin : compare
    res_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = exp_q[0];
          check("q_exe_out", bus.exe_out, e.val);
          check("q_z_flag",  {31'd0, bus.z_flag}, {31'd0, e.z});
          check("q_pc_out",  bus.pc_out, e.pc);
          check("q_rd_out",  {28'd0, bus.rd_out}, {28'd0, e.rd});
          check("q_side",    {29'd0, bus.needs_wb_out, bus.is_load_out, bus.is_store_out},
                             {29'd0, e.wb, e.ld, e.st});
          if (bus.out_ready) exp_q.delete(0);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w, edges, busy_cycles;
    instr_t b_instr;
    rst = 1'b1;
    flush = 1'b0;
    drive(mk(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Spec examples: ADD and a taken LT branch with pc+imm target.
    run_vec("add",    mk(2'b00, 1, 0, 0, 32'd5, 32'd7, 32'd0, 32'h0, 4'd0, 4'd1), 32'd12, 1'b0);
    run_vec("br_lt",  mk(2'b01, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd0, 4'd2),
            32'h120, 1'b1);

    // Operation coverage, each with a hand-computed result and condition.
    run_vec("sub",    mk(2'b00, 1, 0, 0, 32'd3, 32'd5, 32'd1, 32'h10, 4'd0, 4'd1), 32'hFFFF_FFFE, 1'b1);
    run_vec("and",    mk(2'b00, 1, 0, 0, 32'hF0F0, 32'hFF00, 32'd2, 32'h14, 4'd3, 4'd2), 32'hF000, 1'b1);
    run_vec("or",     mk(2'b00, 1, 0, 0, 32'hF0F0, 32'hFF00, 32'd3, 32'h18, 4'd0, 4'd3), 32'hFFF0, 1'b0);
    run_vec("xor",    mk(2'b00, 1, 0, 0, 32'hF0F0, 32'hFF00, 32'd4, 32'h1C, 4'd0, 4'd4), 32'h0FF0, 1'b1);
    run_vec("sll",    mk(2'b10, 1, 0, 0, 32'd1, 32'hDEAD, 32'd31, 32'h0, 4'd5, 4'd3), 32'h8000_0000, 1'b0);
    run_vec("srl",    mk(2'b10, 1, 0, 0, 32'h8000_0000, 32'd0, 32'h24, 32'h0, 4'd6, 4'd4), 32'h0800_0000, 1'b0);
    run_vec("sra",    mk(2'b10, 1, 0, 0, 32'h8000_0000, 32'd0, 32'd4, 32'h0, 4'd7, 4'd5), 32'hF800_0000, 1'b0);
    run_vec("slt",    mk(2'b00, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h0, 4'd0, 4'd6), 32'd1, 1'b0);
    run_vec("sltu",   mk(2'b00, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd9, 32'h0, 4'd0, 4'd7), 32'd0, 1'b0);
    run_vec("op12",   mk(2'b00, 1, 0, 0, 32'd5, 32'd6, 32'd12, 32'h0, 4'd0, 4'd8), 32'd0, 1'b0);
    run_vec("load",   mk(2'b00, 1, 1, 0, 32'h1000, 32'h77, 32'h10, 32'h0, 4'd0, 4'd6), 32'h1010, 1'b0);
    run_vec("store",  mk(2'b11, 1, 0, 1, 32'd8, 32'h99, 32'd8, 32'h0, 4'd0, 4'd7), 32'd16, 1'b1);
    run_vec("br_geu", mk(2'b01, 0, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h200, 4'd0, 4'd5),
            32'h1F0, 1'b0);
    run_vec("br_eq",  mk(2'b01, 0, 0, 0, 32'd7, 32'd7, 32'd8, 32'h4, 4'd0, 4'd0), 32'hC, 1'b1);

    // MUL: busy for XLEN cycles, result XLEN+1 edges after accept, stage closed meanwhile.
    issue(mk(2'b00, 1, 0, 0, 32'hFFFF_FFFF, 32'd3, 32'd10, 32'h40, 4'd0, 4'd8), w);
    wait_valid(edges, busy_cycles, 1'b1);
    check("mul_latency", edges, 33);
    check("mul_busy_cycles", busy_cycles, 32);
    check("mul_val", bus.exe_out, 32'hFFFF_FFFD);
    @(negedge clk);

    // Back-pressure: held result stays put and blocks the next instruction.
    bus.out_ready = 1'b0;
    issue(mk(2'b10, 1, 0, 0, 32'd100, 32'd0, 32'd23, 32'h80, 4'd0, 4'd9), w);
    b_instr = mk(2'b00, 1, 0, 0, 32'd40, 32'd2, 32'd0, 32'h84, 4'd0, 4'd10);
    drive(b_instr);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_held_val", bus.exe_out, 32'd123);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    issue(b_instr, w);
    check("bp_release_wait", w, 0);
    #1;
    check("bp_next_val", bus.exe_out, 32'd42);
    @(negedge clk);

    // Stream: four ADDs accepted on consecutive edges with no bubbles.
    for (int k = 1; k <= 4; k++) begin
      issue(mk(2'b00, 1, 0, 0, k, 32'd10 * k, 32'd0, 32'h100 + 4 * k, 4'd0, 4'(k)), w);
      check("stream_wait", w, 0);
    end
    #1;
    check("stream_last_val", bus.exe_out, 32'd44);
    @(negedge clk);

    // Flush during the 10th multiply cycle aborts it cleanly.
    issue(mk(2'b10, 1, 0, 0, 32'd6, 32'd0, 32'd7, 32'h0, 4'd10, 4'd1), w);
    repeat (9) @(negedge clk);
    #1;
    check("pre_flush_busy", {31'd0, bus.busy}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    repeat (40) @(negedge clk);
    #1;
    check("flush_no_result", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);

    // A second MUL with imm operand and sidebands, then reset mid-multiply.
    issue(mk(2'b10, 1, 0, 0, 32'h1234_5678, 32'd0, 32'h10, 32'h44, 4'd10, 4'd3), w);
    wait_valid(edges, busy_cycles, 1'b0);
    check("mul2_val", bus.exe_out, 32'h2345_6780);
    @(negedge clk);
    issue(mk(2'b00, 1, 0, 0, 32'd9, 32'd9, 32'd10, 32'h48, 4'd0, 4'd5), w);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("rst_mid_mul");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("rst_no_result", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    run_vec("post_rst_add", mk(2'b00, 1, 0, 0, 32'd1000, 32'd24, 32'd0, 32'h0, 4'd0, 4'd1), 32'd1024, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
